// File: rtl/write_back_pkg.sv
// write_back_pkg: shared types and constants for the write-back stage.
//   regval_t  : one 32-bit architectural register value
//   regind_t  : 5-bit register index
//   regfile_t : the full 32x32 architectural register file
//   R0/Flags/Pc          : special register indices
//   FlagCarry..FlagZero  : bit positions of the condition flags in registers[Flags]
//   wb_state_t           : write-back sequencing states
package write_back_pkg;

   typedef logic [31:0]          regval_t;
   typedef logic [4:0]           regind_t;
   typedef logic [31:0][31:0]    regfile_t;

   localparam regind_t R0    = 5'd0;
   localparam regind_t Flags = 5'd30;
   localparam regind_t Pc    = 5'd31;

   localparam int unsigned FlagCarry    = 30;
   localparam int unsigned FlagNegative = 29;
   localparam int unsigned FlagOverflow = 28;
   localparam int unsigned FlagZero     = 27;

   typedef enum logic [1:0] {
      Idle  = 2'd0,
      Upper = 2'd1,
      Store = 2'd2
   } wb_state_t;

endpackage

// File: rtl/write_back.sv
// write_back: final pipeline stage. Commits one execute result per cycle to
// the architectural register file, Flags, PC or data memory, and sequences
// two-cycle commits (upper halves) and bus-stalled stores.
// Ports:
//   clock, reset_n              : clock, asynchronous active-low reset
//   is_valid / hold             : flow control with execute (hold = stall)
//   pc, destination_register,
//   is_writing_memory, flags,
//   destination_value,
//   has_upper_value, upper_value,
//   adjustment_value, has_flushed : incoming execute result
//   registers                   : architectural register file
//   mem_address, mem_writedata,
//   mem_write, mem_waitrequest  : data-memory store port
//   redirect_valid, redirect_pc : pulse when an instruction writes Pc
//   retired                     : pulse per committed instruction
module write_back
   import write_back_pkg::*;
#(
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter logic [31:0] RESET_PC      = 32'h0
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     is_valid,
   output logic                     hold,
   input  logic [31:0]              pc,
   input  logic [4:0]               destination_register,
   input  logic                     is_writing_memory,
   input  logic [3:0]               flags,
   input  logic [31:0]              destination_value,
   input  logic                     has_upper_value,
   input  logic [31:0]              upper_value,
   input  logic [31:0]              adjustment_value,
   input  logic                     has_flushed,
   output regfile_t                 registers,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   output logic [31:0]              mem_writedata,
   output logic                     mem_write,
   input  logic                     mem_waitrequest,
   output logic                     redirect_valid,
   output logic [31:0]              redirect_pc,
   output logic                     retired
);

   wb_state_t                state_r;
   wb_state_t                state_next_s;
   regfile_t                 registers_r;
   regval_t                  upper_value_r;
   regind_t                  upper_index_r;
   logic [ADDRESS_WIDTH-1:0] mem_address_r;
   logic [31:0]              mem_writedata_r;
   logic                     mem_write_r;
   logic                     redirect_valid_r;
   logic [31:0]              redirect_pc_r;
   logic                     retired_r;

   logic                     hold_s;
   logic                     commit_s;
   logic                     store_s;
   logic                     upper_s;
   logic [ADDRESS_WIDTH-1:0] store_address_s;

   // hold depends only on the state so execute sees no loop through is_valid
   assign hold_s = (state_r != Idle);

   // Classify the incoming entry; flushed entries are accepted but have no effect
   always_comb begin
      commit_s        = is_valid && !hold_s && !has_flushed;
      store_s         = commit_s && is_writing_memory;
      upper_s         = commit_s && has_upper_value && !is_writing_memory;
      store_address_s = ADDRESS_WIDTH'(registers_r[destination_register] + adjustment_value);
   end

   // FSM next-state logic
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         Idle: begin
            if (store_s) begin
               state_next_s = Store;
            end else if (upper_s) begin
               state_next_s = Upper;
            end else begin
               state_next_s = Idle;
            end
         end
         Upper: begin
            state_next_s = Idle;
         end
         Store: begin
            if (!mem_waitrequest) begin
               state_next_s = Idle;
            end else begin
               state_next_s = Store;
            end
         end
         default: begin
            state_next_s = Idle;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= Idle;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Register-file write port, store port and retire/redirect pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         registers_r      <= '0;
         registers_r[Pc]  <= RESET_PC;
         upper_value_r    <= 32'h0;
         upper_index_r    <= 5'd0;
         mem_address_r    <= '0;
         mem_writedata_r  <= 32'h0;
         mem_write_r      <= 1'b0;
         redirect_valid_r <= 1'b0;
         redirect_pc_r    <= 32'h0;
         retired_r        <= 1'b0;
      end else begin
         retired_r        <= 1'b0;
         redirect_valid_r <= 1'b0;
         if (store_s) begin
            // Stores only advance Pc; flags and registers are untouched
            registers_r[Pc] <= pc + 32'd4;
            mem_address_r   <= store_address_s;
            mem_writedata_r <= destination_value;
            mem_write_r     <= 1'b1;
         end else if (commit_s) begin
            // Later assignments win: explicit destination beats flag update and pc+4
            registers_r[Pc]                  <= pc + 32'd4;
            registers_r[Flags][FlagCarry]    <= flags[3];
            registers_r[Flags][FlagNegative] <= flags[2];
            registers_r[Flags][FlagOverflow] <= flags[1];
            registers_r[Flags][FlagZero]     <= flags[0];
            if (destination_register != R0) begin
               registers_r[destination_register] <= destination_value;
            end
            if (destination_register == Pc) begin
               redirect_valid_r <= 1'b1;
               redirect_pc_r    <= destination_value;
            end
            if (has_upper_value) begin
               // Retire is deferred to the Upper cycle so only one pulse is seen
               upper_value_r <= upper_value;
               upper_index_r <= destination_register + 5'd1;
            end else begin
               retired_r <= 1'b1;
            end
         end else if (state_r == Upper) begin
            if (upper_index_r != R0) begin
               registers_r[upper_index_r] <= upper_value_r;
            end
            retired_r <= 1'b1;
         end else if ((state_r == Store) && !mem_waitrequest) begin
            mem_write_r <= 1'b0;
            retired_r   <= 1'b1;
         end
      end
   end

   assign hold           = hold_s;
   assign registers      = registers_r;
   assign mem_address    = mem_address_r;
   assign mem_writedata  = mem_writedata_r;
   assign mem_write      = mem_write_r;
   assign redirect_valid = redirect_valid_r;
   assign redirect_pc    = redirect_pc_r;
   assign retired        = retired_r;

endmodule

// File: tb/tb_write_back.sv
// tb_write_back: directed self-checking bench for write_back.
module tb_write_back;
   import write_back_pkg::*;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_1000;

   logic        clock;
   logic        reset_n;
   logic        is_valid;
   logic        hold;
   logic [31:0] pc;
   logic [4:0]  destination_register;
   logic        is_writing_memory;
   logic [3:0]  flags;
   logic [31:0] destination_value;
   logic        has_upper_value;
   logic [31:0] upper_value;
   logic [31:0] adjustment_value;
   logic        has_flushed;
   regfile_t    registers;
   logic [31:0] mem_address;
   logic [31:0] mem_writedata;
   logic        mem_write;
   logic        mem_waitrequest;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        retired;

   int n_checks;
   int n_pass;

   write_back #(
      .ADDRESS_WIDTH(32),
      .RESET_PC     (TB_RESET_PC)
   ) dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .is_valid            (is_valid),
      .hold                (hold),
      .pc                  (pc),
      .destination_register(destination_register),
      .is_writing_memory   (is_writing_memory),
      .flags               (flags),
      .destination_value   (destination_value),
      .has_upper_value     (has_upper_value),
      .upper_value         (upper_value),
      .adjustment_value    (adjustment_value),
      .has_flushed         (has_flushed),
      .registers           (registers),
      .mem_address         (mem_address),
      .mem_writedata       (mem_writedata),
      .mem_write           (mem_write),
      .mem_waitrequest     (mem_waitrequest),
      .redirect_valid      (redirect_valid),
      .redirect_pc         (redirect_pc),
      .retired             (retired)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Present one entry for a single cycle; returns #1 after the accepting edge
   task automatic issue(input logic [4:0] dest, input logic [31:0] value, input logic [3:0] flg,
                        input logic up_en, input logic [31:0] up_val, input logic store,
                        input logic [31:0] adj, input logic flushed, input logic [31:0] ipc);
      @(negedge clock);
      is_valid             = 1'b1;
      destination_register = dest;
      destination_value    = value;
      flags                = flg;
      has_upper_value      = up_en;
      upper_value          = up_val;
      is_writing_memory    = store;
      adjustment_value     = adj;
      has_flushed          = flushed;
      pc                   = ipc;
      @(posedge clock);
      #1;
      is_valid = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset_n = 1'b0;
      is_valid = 1'b0;
      pc = 32'h0;
      destination_register = 5'd0;
      is_writing_memory = 1'b0;
      flags = 4'b0000;
      destination_value = 32'h0;
      has_upper_value = 1'b0;
      upper_value = 32'h0;
      adjustment_value = 32'h0;
      has_flushed = 1'b0;
      mem_waitrequest = 1'b0;

      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      #1;
      check_val("reset_pc", registers[Pc], TB_RESET_PC);
      check_val("reset_r5", registers[5], 32'h0);
      check_val("reset_hold", {31'h0, hold}, 32'h0);
      check_val("reset_mem_write", {31'h0, mem_write}, 32'h0);
      check_val("reset_retired", {31'h0, retired}, 32'h0);

      // Add result
      issue(5'd5, 32'h0000_1234, 4'b1001, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_0100);
      check_val("add_r5", registers[5], 32'h0000_1234);
      check_val("add_flags", registers[Flags], 32'h4800_0000);
      check_val("add_pc", registers[Pc], 32'h0000_0104);
      check_val("add_retired", {31'h0, retired}, 32'h1);
      @(posedge clock); #1;
      check_val("add_retired_drop", {31'h0, retired}, 32'h0);

      // Multiply with upper half to r7
      issue(5'd6, 32'hFFFF_0000, 4'b0000, 1'b1, 32'h0000_0001, 1'b0, 32'h0, 1'b0, 32'h0000_0104);
      check_val("mul_r6", registers[6], 32'hFFFF_0000);
      check_val("mul_hold", {31'h0, hold}, 32'h1);
      check_val("mul_retired_c1", {31'h0, retired}, 32'h0);
      check_val("mul_flags_clear", registers[Flags], 32'h0);
      @(posedge clock); #1;
      check_val("mul_r7", registers[7], 32'h0000_0001);
      check_val("mul_hold_drop", {31'h0, hold}, 32'h0);
      check_val("mul_retired_c2", {31'h0, retired}, 32'h1);
      @(posedge clock); #1;
      check_val("mul_retired_once", {31'h0, retired}, 32'h0);

      // Multiply into Pc: upper wraps to R0 and is dropped
      issue(5'd31, 32'h0000_0200, 4'b0000, 1'b1, 32'h0000_DEAD, 1'b0, 32'h0, 1'b0, 32'h0000_0108);
      check_val("mulpc_pc", registers[Pc], 32'h0000_0200);
      check_val("mulpc_redirect", {31'h0, redirect_valid}, 32'h1);
      check_val("mulpc_redirect_pc", redirect_pc, 32'h0000_0200);
      @(posedge clock); #1;
      check_val("mulpc_r0", registers[0], 32'h0);
      check_val("mulpc_retired", {31'h0, retired}, 32'h1);
      check_val("mulpc_redirect_drop", {31'h0, redirect_valid}, 32'h0);

      // Write to R0 is ignored
      issue(5'd0, 32'h0000_FFFF, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_0200);
      check_val("r0_write", registers[0], 32'h0);

      // Set r3 as store base
      issue(5'd3, 32'h0000_0100, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_0300);
      check_val("r3_set", registers[3], 32'h0000_0100);

      // Store with three wait cycles
      mem_waitrequest = 1'b1;
      issue(5'd3, 32'h0000_CAFE, 4'b1111, 1'b1, 32'h0000_BEEF, 1'b1, 32'h0000_0008, 1'b0, 32'h0000_0304);
      check_val("st_mem_write", {31'h0, mem_write}, 32'h1);
      check_val("st_addr", mem_address, 32'h0000_0108);
      check_val("st_data", mem_writedata, 32'h0000_CAFE);
      check_val("st_hold", {31'h0, hold}, 32'h1);
      check_val("st_pc", registers[Pc], 32'h0000_0308);
      for (int i = 0; i < 3; i++) begin
         @(posedge clock); #1;
         check_val("st_wait_mem_write", {31'h0, mem_write}, 32'h1);
         check_val("st_wait_addr", mem_address, 32'h0000_0108);
         check_val("st_wait_hold", {31'h0, hold}, 32'h1);
         check_val("st_wait_retired", {31'h0, retired}, 32'h0);
      end
      mem_waitrequest = 1'b0;
      @(posedge clock); #1;
      check_val("st_done_mem_write", {31'h0, mem_write}, 32'h0);
      check_val("st_done_retired", {31'h0, retired}, 32'h1);
      check_val("st_done_hold", {31'h0, hold}, 32'h0);
      check_val("st_flags", registers[Flags], 32'h0);
      check_val("st_r3", registers[3], 32'h0000_0100);
      check_val("st_r4_upper", registers[4], 32'h0);

      // Branch
      issue(5'd31, 32'h0000_0400, 4'b0000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0000_0308);
      check_val("br_redirect", {31'h0, redirect_valid}, 32'h1);
      check_val("br_redirect_pc", redirect_pc, 32'h0000_0400);
      check_val("br_pc", registers[Pc], 32'h0000_0400);
      check_val("br_retired", {31'h0, retired}, 32'h1);
      @(posedge clock); #1;
      check_val("br_redirect_drop", {31'h0, redirect_valid}, 32'h0);

      // Flushed entry
      issue(5'd4, 32'h0000_0055, 4'b1111, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0500);
      check_val("fl_r4", registers[4], 32'h0);
      check_val("fl_flags", registers[Flags], 32'h0);
      check_val("fl_pc", registers[Pc], 32'h0000_0400);
      check_val("fl_retired", {31'h0, retired}, 32'h0);

      // Reset during a stalled store
      mem_waitrequest = 1'b1;
      issue(5'd3, 32'h0000_0077, 4'b0000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 32'h0000_0600);
      check_val("rs_mem_write_before", {31'h0, mem_write}, 32'h1);
      #2;
      reset_n = 1'b0;
      #1;
      check_val("rs_mem_write", {31'h0, mem_write}, 32'h0);
      check_val("rs_hold", {31'h0, hold}, 32'h0);
      check_val("rs_pc", registers[Pc], TB_RESET_PC);
      check_val("rs_r3", registers[3], 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      mem_waitrequest = 1'b0;
      @(posedge clock); #1;
      check_val("rs_idle_hold", {31'h0, hold}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/write_back.md
# write_back

Final pipeline stage: accepts one result per cycle from the execute stage and commits it to the architectural register file, Flags register, PC, or data memory. It owns the `regfile_t` state that the execute stage reads. It also sequences two-cycle commits (multiply/divide upper halves) and bus-stalled stores, stalling execute through the flow-control hold.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, data-memory byte-address width
- RESET_PC, 32'h0, PC value loaded at reset

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- is_valid  in  1  execute-stage output holds a result this cycle (flow_in.is_valid)
- hold  out  1  stall request to execute (flow_in.hold)
- pc  in  32  PC of the incoming instruction
- destination_register  in  5  target register index, or address register for stores
- is_writing_memory  in  1  result is a store
- flags  in  4  {carry, negative, overflow, zero}
- destination_value  in  32  result, or store data
- has_upper_value  in  1  upper_value must also be committed
- upper_value  in  32  high product word or remainder
- adjustment_value  in  32  store address offset
- has_flushed  in  1  instruction was squashed upstream
- registers  out  32x32  architectural register file (regfile_t)
- mem_address  out  ADDRESS_WIDTH  store address
- mem_writedata  out  32  store data
- mem_write  out  1  store request
- mem_waitrequest  in  1  bus not ready; keep request stable
- redirect_valid  out  1  one-cycle pulse: PC written by instruction
- redirect_pc  out  32  redirect target
- retired  out  1  one-cycle pulse per committed instruction

## Operation
- Register constants: R0 = 0 (reads 0, writes ignored), Flags = 30, Pc = 31.
- Flags layout in registers[Flags]: carry bit 30, negative bit 29, overflow bit 28, zero bit 27. All other bits hold their value.
- An input is accepted when is_valid && !hold. Accepted entries with has_flushed=1 retire with no architectural effect: no writes, no retired pulse.
- **Normal commit (IDLE):**
  - Write destination_value to destination_register, unless the index is R0.
  - Update Flags bits 30:27 from flags. An explicit write to Flags wins over the flag update.
  - Write registers[Pc] = pc+4, unless destination is Pc. In that case registers[Pc] = destination_value and redirect_valid pulses with redirect_pc = destination_value.
- **Upper commit:** has_upper_value && !is_writing_memory.
  - Cycle 1 performs the normal commit.
  - FSM enters UPPER and writes upper_value to register (destination_register+1) mod 32. The write is skipped if that index is R0.
- **Store:** is_writing_memory=1.
  - mem_address = registers[destination_register] + adjustment_value, truncated to ADDRESS_WIDTH.
  - mem_writedata = destination_value.
  - FSM enters STORE. Flags and the register file are not written, except Pc = pc+4.
  - has_upper_value is ignored for stores.
- **FSM states:**
  - IDLE -> UPPER on an accepted upper commit.
  - IDLE -> STORE on an accepted store.
  - UPPER -> IDLE after 1 cycle.
  - STORE -> IDLE on the first cycle with mem_waitrequest=0.

## Timing
- Reset values: all registers 0 except Pc = RESET_PC. mem_write, redirect_valid, retired = 0. mem_address, mem_writedata = 0. FSM = IDLE. hold = 0.
- Normal commit: register write visible on `registers` the cycle after acceptance. retired pulses in that same cycle.
- Upper commit: hold = 1 combinationally while in UPPER. The upper write becomes visible 2 cycles after acceptance. retired pulses once, in the UPPER-exit cycle.
- Store: mem_write asserts the cycle after acceptance. Address and data stay stable while mem_waitrequest=1; hold = 1 throughout STORE. The cycle with mem_waitrequest=0 completes the transfer; mem_write drops the next cycle and retired pulses then.
- An accepted input in the cycle the FSM returns to IDLE is legal, giving back-to-back commits with no bubble.
- hold is only asserted in UPPER/STORE and never depends on is_valid. This avoids a combinational loop with execute.
- Reset mid-STORE aborts the transfer immediately: mem_write drops asynchronously. No partial commit occurs.

## Structure
- Shared package gains: R0, Flags, Pc register constants; flag bit positions (FlagCarry=30, FlagNegative=29, FlagOverflow=28, FlagZero=27); the FSM state enum (Idle, Upper, Store). The package already provides regfile_t, regval_t and regind_t.
- Flat module. No sub-module is warranted: the register-file write port is a single always_ff inside this block.

## Test plan
- Add result: dest=5, value=32'h1234, flags=4'b1001 -> next cycle r5=32'h1234, Flags[30:27]=4'b1001, Pc=pc+4, retired=1.
- Multiply: dest=6, value=32'hFFFF_0000, upper=32'h0000_0001 -> r6 written in cycle 1, hold=1 in cycle 2, r7=1 in cycle 2, one retired pulse. Repeat with dest=31 -> upper to r0 is dropped.
- Store: r3=32'h100, adjustment=8, data=32'hCAFE, mem_waitrequest held high 3 cycles -> mem_write high 4 cycles at address 32'h108, hold high throughout, no register or Flags change.
- Branch: dest=Pc, value=32'h400 -> redirect_valid one-cycle pulse with redirect_pc=32'h400, registers[Pc]=32'h400.
- Flushed entry, dest=4, has_flushed=1 -> r4, Flags and Pc unchanged, retired stays 0.
- Assert reset_n low while in STORE with mem_waitrequest=1 -> mem_write=0 immediately, FSM=IDLE, Pc=RESET_PC.
